// File: rtl/mem_access_stage.sv
// MEM pipeline stage: RISC-V load/store lane steering over a req/ack data bus.
// Optional misaligned-access trap is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        mem_RegWrite,
  input  logic        mem_MemtoReg,
  input  logic        mem_MemRead,
  input  logic        mem_MemWrite,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_write_data,
  input  logic [4:0]  mem_rd,
  input  logic [2:0]  mem_funct3,
  output logic        stall_out,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_wstrb,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        wb_valid,
  output logic        wb_RegWrite,
  output logic        wb_MemtoReg,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_mem_data,
  output logic        bus_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;

  logic        req_rw_p1, req_m2r_p1;
  logic [4:0]  req_rd_p1;
  logic [31:0] req_alu_p1;
  logic [2:0]  req_f3_p1;

  logic        skid_vld_p1, skid_rw_p1, skid_m2r_p1, skid_err_p1;
  logic [4:0]  skid_rd_p1;
  logic [31:0] skid_alu_p1;

  logic accept, is_mem, trap, mem_go, direct, ack_done, tmo;

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] store_wstrb(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] word);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] ext;
    byte_s = word[{a, 3'b000} +: 8];
    half_s = a[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  ext = byte_s;
      3'b100:  ext = {24'd0, byte_s};
      3'b001:  ext = half_s;
      3'b101:  ext = {16'd0, half_s};
      default: ext = word;
    endcase
    return ext;
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  assign trap = is_mem && misaligned(mem_funct3, mem_alu_result[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign stall_out = (state == BUSY) && !dbus_ack;
  assign accept    = in_valid && !stall_out;
  assign is_mem    = mem_MemRead || mem_MemWrite;
  assign mem_go    = accept && is_mem && !trap;
  assign direct    = accept && !mem_go;
  assign ack_done  = (state == BUSY) && dbus_ack;
  assign tmo       = (state == BUSY) && !dbus_ack && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (mem_go) state_next = BUSY;
      BUSY: begin
        if (ack_done)  state_next = mem_go ? BUSY : IDLE;
        else if (tmo)  state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stage p1: bus request, skid slot and MEM/WB register.
  // The skid slot holds a non-memory bundle accepted on the ack edge, since
  // the load/store result claims the MEM/WB register on that same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt           <= '0;
      dbus_req      <= 1'b0;
      dbus_we       <= 1'b0;
      dbus_addr     <= '0;
      dbus_wdata    <= '0;
      dbus_wstrb    <= '0;
      wb_valid      <= 1'b0;
      wb_RegWrite   <= 1'b0;
      wb_MemtoReg   <= 1'b0;
      wb_rd         <= '0;
      wb_alu_result <= '0;
      wb_mem_data   <= '0;
      bus_err       <= 1'b0;
      skid_vld_p1   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      bus_err  <= 1'b0;
      if (state == BUSY) cnt <= cnt + 1'b1;
      if (mem_go) begin
        cnt        <= '0;
        dbus_req   <= 1'b1;
        dbus_we    <= mem_MemWrite;
        dbus_addr  <= {mem_alu_result[31:2], 2'b00};
        dbus_wdata <= mem_MemWrite ? store_wdata(mem_funct3, mem_write_data) : '0;
        dbus_wstrb <= mem_MemWrite ? store_wstrb(mem_funct3, mem_alu_result[1:0]) : 4'b0000;
      end else if (ack_done || tmo) begin
        dbus_req <= 1'b0;
      end
      skid_vld_p1 <= direct && (ack_done || skid_vld_p1);
      if (ack_done || tmo) begin
        wb_valid      <= 1'b1;
        wb_RegWrite   <= ack_done && req_rw_p1;
        wb_MemtoReg   <= req_m2r_p1;
        wb_rd         <= req_rd_p1;
        wb_alu_result <= req_alu_p1;
        wb_mem_data   <= (ack_done && !dbus_we) ?
                         load_extend(req_f3_p1, req_alu_p1[1:0], dbus_rdata) : '0;
        bus_err       <= tmo;
      end else if (skid_vld_p1) begin
        wb_valid      <= 1'b1;
        wb_RegWrite   <= skid_rw_p1;
        wb_MemtoReg   <= skid_m2r_p1;
        wb_rd         <= skid_rd_p1;
        wb_alu_result <= skid_alu_p1;
        wb_mem_data   <= '0;
        bus_err       <= skid_err_p1;
      end else if (direct) begin
        wb_valid      <= 1'b1;
        wb_RegWrite   <= mem_RegWrite && !trap;
        wb_MemtoReg   <= mem_MemtoReg;
        wb_rd         <= mem_rd;
        wb_alu_result <= mem_alu_result;
        wb_mem_data   <= '0;
        bus_err       <= trap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_go) begin
      req_rw_p1  <= mem_RegWrite;
      req_m2r_p1 <= mem_MemtoReg;
      req_rd_p1  <= mem_rd;
      req_alu_p1 <= mem_alu_result;
      req_f3_p1  <= mem_funct3;
    end
    if (direct) begin
      skid_rw_p1  <= mem_RegWrite && !trap;
      skid_m2r_p1 <= mem_MemtoReg;
      skid_err_p1 <= trap;
      skid_rd_p1  <= mem_rd;
      skid_alu_p1 <= mem_alu_result;
    end
  end

endmodule
